// File: rtl/pim_bridge.sv
// pim_bridge: IDS bus PIM-port slave that turns mapped bus writes into typed
// macro commands (command FIFO, valid/ready issue) and buffers macro results
// in a second FIFO popped by bus reads of PIM_R.
module pim_bridge #(
   parameter int unsigned     XLEN             = 32,
   parameter int unsigned     CMD_DEPTH        = 8,
   parameter int unsigned     RES_DEPTH        = 8,
   parameter logic [XLEN-1:0] PIM_CTRL         = 32'h4000_0010,
   parameter logic [XLEN-1:0] PIM_R            = 32'h4000_0020,
   parameter logic [XLEN-1:0] PIM_W_WEIGHT     = 32'h4000_0040,
   parameter logic [XLEN-1:0] PIM_W_ACTIVATION = 32'h4000_0080
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [XLEN-1:0] i_pim_addr,
   input  logic            i_pim_write,
   input  logic            i_pim_read,
   input  logic [3:0]      i_pim_size,
   input  logic [XLEN-1:0] i_pim_din,
   output logic [XLEN-1:0] o_pim_dout,
   output logic            o_mac_valid,
   input  logic            i_mac_ready,
   output logic [1:0]      o_mac_type,
   output logic [XLEN-1:0] o_mac_data,
   input  logic            i_res_valid,
   output logic            o_res_ready,
   input  logic [XLEN-1:0] i_res_data
);

   localparam int unsigned CPW = $clog2(CMD_DEPTH);
   localparam int unsigned CW  = CPW + 1;
   localparam int unsigned RPW = $clog2(RES_DEPTH);
   localparam int unsigned RW  = RPW + 1;
   localparam logic [CW-1:0] CMD_MAX = CW'(CMD_DEPTH);
   localparam logic [RW-1:0] RES_MAX = RW'(RES_DEPTH);

   typedef enum logic [1:0] {
      CMD_CTRL   = 2'd0,
      CMD_WEIGHT = 2'd1,
      CMD_ACT    = 2'd2
   } cmd_type_t;

   logic [1:0]      cmd_type_mem [CMD_DEPTH];
   logic [XLEN-1:0] cmd_data_mem [CMD_DEPTH];
   logic [CPW-1:0]  cmd_wr_ptr, cmd_rd_ptr;
   logic [CW-1:0]   cmd_count;

   logic [XLEN-1:0] res_mem [RES_DEPTH];
   logic [RPW-1:0]  res_wr_ptr, res_rd_ptr;
   logic [RW-1:0]   res_count, res_count_next;

   logic            ovf, udf, res_ready_q;
   logic [XLEN-1:0] dout_q, rd_data, status;

   cmd_type_t       push_type;
   logic            cmd_req, cmd_push, cmd_pop, cmd_drop, sticky_clr;
   logic            res_push, res_pop, res_udf, rd_res;

   // Write decode: exact address match, full-word writes only
   always_comb begin
      cmd_req    = 1'b0;
      push_type  = CMD_CTRL;
      sticky_clr = 1'b0;
      if (i_pim_write && (i_pim_size == 4'hF)) begin
         if (i_pim_addr == PIM_W_WEIGHT) begin
            cmd_req   = 1'b1;
            push_type = CMD_WEIGHT;
         end else if (i_pim_addr == PIM_W_ACTIVATION) begin
            cmd_req   = 1'b1;
            push_type = CMD_ACT;
         end else if (i_pim_addr == PIM_CTRL) begin
            if (i_pim_din[XLEN-1]) sticky_clr = 1'b1;
            else                   cmd_req    = 1'b1;
         end
      end
   end

   // FIFO handshakes; a full command FIFO still accepts when the head leaves this cycle
   always_comb begin
      cmd_pop  = (cmd_count != '0) && i_mac_ready;
      cmd_push = cmd_req && ((cmd_count != CMD_MAX) || cmd_pop);
      cmd_drop = cmd_req && !cmd_push;
      res_push = i_res_valid && res_ready_q;
      rd_res   = i_pim_read && (i_pim_addr == PIM_R);
      res_pop  = rd_res && (res_count != '0);
      res_udf  = rd_res && (res_count == '0);
      case ({res_push, res_pop})
         2'b10:   res_count_next = res_count + RW'(1);
         2'b01:   res_count_next = res_count - RW'(1);
         default: res_count_next = res_count;
      endcase
   end

   // Status word and bus read mux, both from pre-edge state
   always_comb begin
      status        = '0;
      status[0]     = (cmd_count == CMD_MAX);
      status[1]     = (cmd_count == '0);
      status[2]     = (res_count == RES_MAX);
      status[3]     = (res_count == '0);
      status[4]     = ovf;
      status[5]     = udf;
      status[15:8]  = 8'(cmd_count);
      status[23:16] = 8'(res_count);
      rd_data       = '0;
      if (i_pim_addr == PIM_CTRL)                        rd_data = status;
      else if ((i_pim_addr == PIM_R) && (res_count != '0)) rd_data = res_mem[res_rd_ptr];
   end

   // FIFO storage (no reset needed; validity tracked by counts)
   always_ff @(posedge i_clk) begin
      if (cmd_push) begin
         cmd_type_mem[cmd_wr_ptr] <= push_type;
         cmd_data_mem[cmd_wr_ptr] <= i_pim_din;
      end
      if (res_push) res_mem[res_wr_ptr] <= i_res_data;
   end

   // Pointers, counts, sticky flags, registered ready and read data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cmd_wr_ptr  <= '0;
         cmd_rd_ptr  <= '0;
         cmd_count   <= '0;
         res_wr_ptr  <= '0;
         res_rd_ptr  <= '0;
         res_count   <= '0;
         ovf         <= 1'b0;
         udf         <= 1'b0;
         res_ready_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CPW'(1);
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CPW'(1);
         case ({cmd_push, cmd_pop})
            2'b10:   cmd_count <= cmd_count + CW'(1);
            2'b01:   cmd_count <= cmd_count - CW'(1);
            default: cmd_count <= cmd_count;
         endcase
         if (res_push) res_wr_ptr <= res_wr_ptr + RPW'(1);
         if (res_pop)  res_rd_ptr <= res_rd_ptr + RPW'(1);
         res_count   <= res_count_next;
         // ready reflects the post-edge count so a full FIFO never sees an extra push
         res_ready_q <= (res_count_next != RES_MAX);
         ovf         <= (ovf & ~sticky_clr) | cmd_drop;
         udf         <= (udf & ~sticky_clr) | res_udf;
         if (i_pim_read) dout_q <= rd_data;
      end
   end

   // Macro issue: head entry, driven to zero while the FIFO is empty
   always_comb begin
      o_mac_valid = (cmd_count != '0);
      o_mac_type  = '0;
      o_mac_data  = '0;
      if (o_mac_valid) begin
         o_mac_type = cmd_type_mem[cmd_rd_ptr];
         o_mac_data = cmd_data_mem[cmd_rd_ptr];
      end
   end

   assign o_pim_dout  = dout_q;
   assign o_res_ready = res_ready_q;

endmodule

// File: tb/tb_pim_bridge.sv
// tb_pim_bridge: directed and randomized stimulus against a queue-based
// reference model of the bridge; every cycle checks macro and result ports.
module tb_pim_bridge;

   localparam logic [31:0] A_CTRL = 32'h4000_0010;
   localparam logic [31:0] A_R    = 32'h4000_0020;
   localparam logic [31:0] A_W    = 32'h4000_0040;
   localparam logic [31:0] A_A    = 32'h4000_0080;
   localparam logic [31:0] A_BAD  = 32'h4000_0030;
   localparam int CMD_DEPTH = 8;
   localparam int RES_DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = '0;
   logic        wr = 1'b0, rd = 1'b0;
   logic [3:0]  size = 4'hF;
   logic [31:0] din = '0;
   logic        mac_ready = 1'b0, res_valid = 1'b0;
   logic [31:0] res_data = '0;
   logic [31:0] dout, mac_data;
   logic        mac_valid, res_ready;
   logic [1:0]  mac_type;

   always #5 clk = ~clk;

   pim_bridge #(.XLEN(32), .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pim_addr(addr), .i_pim_write(wr),
      .i_pim_read(rd), .i_pim_size(size), .i_pim_din(din), .o_pim_dout(dout),
      .o_mac_valid(mac_valid), .i_mac_ready(mac_ready), .o_mac_type(mac_type),
      .o_mac_data(mac_data), .i_res_valid(res_valid), .o_res_ready(res_ready),
      .i_res_data(res_data)
   );

   // reference model state
   logic [33:0] cmd_q[$];
   logic [31:0] res_q[$];
   bit          m_ovf, m_udf;
   logic        exp_res_ready = 1'b0;
   logic [31:0] exp_dout = '0;
   int          n_pass = 0, n_total = 0;

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = (cmd_q.size() == CMD_DEPTH);
      s[1] = (cmd_q.size() == 0);
      s[2] = (res_q.size() == RES_DEPTH);
      s[3] = (res_q.size() == 0);
      s[4] = m_ovf;
      s[5] = m_udf;
      s[15:8]  = 8'(cmd_q.size());
      s[23:16] = 8'(res_q.size());
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // one clock: update model from pre-edge state and inputs, then compare
   task automatic cycle();
      logic [31:0] stat;
      logic [1:0]  t;
      bit pop_cmd, push_cmd, pop_res, push_res, req;
      stat     = model_status();
      pop_cmd  = (cmd_q.size() > 0) && mac_ready;
      push_res = res_valid && exp_res_ready;
      pop_res  = 0;
      push_cmd = 0;
      req      = 0;
      t        = 2'd0;
      if (rd) begin
         if (addr == A_CTRL) exp_dout = stat;
         else if (addr == A_R) begin
            if (res_q.size() > 0) begin
               exp_dout = res_q[0];
               pop_res  = 1;
            end else begin
               exp_dout = '0;
               m_udf    = 1;
            end
         end else exp_dout = '0;
      end
      if (wr && size == 4'hF) begin
         if (addr == A_W) begin req = 1; t = 2'd1; end
         else if (addr == A_A) begin req = 1; t = 2'd2; end
         else if (addr == A_CTRL) begin
            if (din[31]) begin m_ovf = 0; m_udf = 0; end
            else begin req = 1; t = 2'd0; end
         end
         if (req) begin
            if (cmd_q.size() < CMD_DEPTH || pop_cmd) push_cmd = 1;
            else m_ovf = 1;
         end
      end
      if (pop_cmd)  void'(cmd_q.pop_front());
      if (push_cmd) cmd_q.push_back({t, din});
      if (pop_res)  void'(res_q.pop_front());
      if (push_res) res_q.push_back(res_data);
      exp_res_ready = (res_q.size() < RES_DEPTH);
      @(posedge clk);
      #1;
      chk("mac_valid", 32'(mac_valid), 32'(cmd_q.size() > 0));
      chk("mac_type", 32'(mac_type), (cmd_q.size() > 0) ? 32'(cmd_q[0][33:32]) : 32'd0);
      chk("mac_data", mac_data, (cmd_q.size() > 0) ? cmd_q[0][31:0] : 32'd0);
      chk("res_ready", 32'(res_ready), 32'(exp_res_ready));
      chk("pim_dout", dout, exp_dout);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; din = d; size = 4'hF; wr = 1'b1;
      cycle();
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      addr = a; rd = 1'b1;
      cycle();
      rd = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // asynchronous reset asserted between clock edges
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mac_valid", 32'(mac_valid), 32'd0);
      chk("rst_mac_data", mac_data, 32'd0);
      chk("rst_mac_type", 32'(mac_type), 32'd0);
      chk("rst_res_ready", 32'(res_ready), 32'd0);
      chk("rst_dout", dout, 32'd0);
      cmd_q.delete();
      res_q.delete();
      m_ovf = 0; m_udf = 0;
      exp_dout = '0;
      exp_res_ready = 1'b0;
      wr = 1'b0; rd = 1'b0; res_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      cycle();
   endtask

   initial begin
      // power-on reset
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      cycle();
      bus_read(A_CTRL);
      chk("reset_status", dout, 32'h0000_000A);

      // overflow: 10 weight writes with macro stalled
      mac_ready = 1'b0;
      for (int i = 0; i < 10; i++) bus_write(A_W, $urandom);
      bus_read(A_CTRL);
      chk("ovf_status", dout, 32'h0000_0819);
      mac_ready = 1'b1;
      idle(10);
      bus_write(A_CTRL, 32'h8000_0000);

      // ordered issue with toggling ready
      mac_ready = 1'b0;
      bus_write(A_W, 32'h11);
      bus_write(A_A, 32'h22);
      bus_write(A_CTRL, 32'h33);
      mac_ready = 1'b1; cycle();
      mac_ready = 1'b0; cycle();
      mac_ready = 1'b1; cycle();
      mac_ready = 1'b0; cycle();
      mac_ready = 1'b1; cycle();
      chk("issue_drained", 32'(mac_valid), 32'd0);

      // results and underflow
      res_valid = 1'b1; res_data = 32'hA5; cycle();
      res_data = 32'h5A; cycle();
      res_valid = 1'b0;
      bus_read(A_R);
      chk("res_first", dout, 32'hA5);
      bus_read(A_R);
      chk("res_second", dout, 32'h5A);
      bus_read(A_R);
      chk("res_empty_read", dout, 32'h0);
      bus_read(A_CTRL);
      chk("udf_status", dout, 32'h0000_002A);
      bus_write(A_CTRL, 32'h8000_0000);
      bus_read(A_CTRL);
      chk("cleared_status", dout, 32'h0000_000A);

      // result FIFO full and back-pressure release
      res_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         res_data = $urandom;
         cycle();
      end
      res_valid = 1'b0;
      chk("res_full_ready", 32'(res_ready), 32'd0);
      bus_read(A_R);
      chk("res_ready_back", 32'(res_ready), 32'd1);
      for (int i = 0; i < 8; i++) bus_read(A_R);

      // randomized traffic, including same-cycle read/write and partial writes
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 4))
            0: addr = A_CTRL;
            1: addr = A_R;
            2: addr = A_W;
            3: addr = A_A;
            default: addr = A_BAD;
         endcase
         wr        = ($urandom_range(0, 1) == 1);
         rd        = ($urandom_range(0, 2) == 0);
         size      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         din       = $urandom;
         if ($urandom_range(0, 7) == 0) din[31] = 1'b1;
         else din[31] = 1'b0;
         mac_ready = ($urandom_range(0, 2) != 0);
         res_valid = ($urandom_range(0, 1) == 1);
         res_data  = $urandom;
         cycle();
      end
      wr = 1'b0; rd = 1'b0; res_valid = 1'b0; size = 4'hF;

      // reset while a command is stalled on the macro
      mac_ready = 1'b0;
      bus_write(A_W, 32'hDEAD_BEEF);
      chk("stalled_valid", 32'(mac_valid), 32'd1);
      async_reset();
      bus_read(A_CTRL);
      chk("post_reset_status", dout, 32'h0000_000A);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
